// File: rtl/mp1000_pkg.sv
// Shared definitions for the MP1000 cartridge loader: FSM states and default
// selector/pad values.
package mp1000_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_PAD,
        ST_DONE
    } loader_state_t;

    localparam logic [7:0] CART_INDEX_DEF = 8'h01;
    localparam logic [7:0] PAD_BYTE_DEF   = 8'hFF;

endpackage

// File: rtl/ioctl_fifo.sv
// Show-ahead synchronous FIFO buffering {address, data} entries between the
// ioctl stream and the cart RAM write port.
module ioctl_fifo
    import mp1000_pkg::*;
#(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mp1000_cart_loader.sv
// MP1000 cartridge loader: consumes the HPS ioctl byte stream, writes it into
// cart RAM through a small buffer, pads the unused ROM tail and tracks status.
module mp1000_cart_loader
    import mp1000_pkg::*;
#(
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] CART_INDEX = CART_INDEX_DEF,
    parameter int         FIFO_DEPTH = 4,
    parameter bit         PAD_EN     = 1'b1,
    parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              ram_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_d,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);

    localparam int FW = ADDR_W + 8;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] ROM_SIZE = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CW-1:0]   WAIT_LVL = CW'(FIFO_DEPTH - 1);

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (v == ROM_SIZE) ? v : v + (ADDR_W+1)'(1);
    endfunction

    loader_state_t state, state_next;

    logic            sel, sel_p1, sel_rise;
    logic            addr_ok, strobe, push_ok, drop;
    logic            stream_en, wr_stream, pad_wr, last_pad;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]   fifo_dout, wr_ent;
    logic [CW-1:0]   fifo_count, count_next;
    logic [ADDR_W:0] hw, pad_addr, wr_end;

    assign sel      = ioctl_download && (ioctl_index == CART_INDEX);
    assign sel_rise = sel && !sel_p1;
    assign addr_ok  = (ioctl_addr[24:ADDR_W] == '0);
    assign strobe   = (state == ST_LOAD) && ioctl_wr && sel;
    assign push_ok  = strobe && addr_ok && !fifo_full;
    assign drop     = strobe && !(addr_ok && !fifo_full);

    // An empty buffer lets a strobe go straight to RAM in the same cycle.
    assign stream_en = ((state == ST_LOAD) || (state == ST_DRAIN)) && !sel_rise;
    assign wr_stream = stream_en && ram_ready && (!fifo_empty || push_ok);
    assign fifo_pop  = stream_en && ram_ready && !fifo_empty;
    assign fifo_push = push_ok && !(fifo_empty && ram_ready);
    assign wr_ent    = fifo_empty ? {ioctl_addr[ADDR_W-1:0], ioctl_dout} : fifo_dout;
    assign wr_end    = {1'b0, wr_ent[FW-1:8]} + (ADDR_W+1)'(1);

    assign last_pad  = (pad_addr[ADDR_W-1:0] == '1);
    assign pad_wr    = (state == ST_PAD) && !sel_rise && ram_ready && !pad_addr[ADDR_W];

    assign count_next = sel_rise ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    ioctl_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .flush (sel_rise),
        .push  (fifo_push),
        .din   ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: state_next = sel_rise ? ST_LOAD : ST_IDLE;
            ST_LOAD:          if (!sel) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (sel_rise)        state_next = ST_LOAD;
                else if (fifo_empty) state_next = PAD_EN ? ST_PAD : ST_DONE;
            end
            ST_PAD: begin
                if (sel_rise)                  state_next = ST_LOAD;
                else if (pad_addr[ADDR_W])     state_next = ST_DONE;
                else if (pad_wr && last_pad)   state_next = ST_DONE;
            end
            default:          state_next = ST_IDLE;
        endcase
    end

    // Output stage: RAM port, counters and status, all registered.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_p1     <= 1'b0;
            ioctl_wait <= 1'b0;
            ram_we     <= 1'b0;
            ram_ad     <= '0;
            ram_d      <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
            hw         <= '0;
            pad_addr   <= '0;
        end else begin
            sel_p1     <= sel;
            ioctl_wait <= (state_next == ST_LOAD) && (count_next >= WAIT_LVL);
            ram_we     <= wr_stream || pad_wr;
            if (wr_stream) begin
                ram_ad <= wr_ent[FW-1:8];
                ram_d  <= wr_ent[7:0];
            end else if (pad_wr) begin
                ram_ad <= pad_addr[ADDR_W-1:0];
                ram_d  <= PAD_BYTE;
            end

            if (sel_rise) begin
                byte_count <= '0;
                checksum   <= '0;
                hw         <= '0;
                load_err   <= 1'b0;
                load_done  <= 1'b0;
                cpu_hold   <= 1'b1;
            end else begin
                if (wr_stream) begin
                    byte_count <= sat_inc(byte_count);
                    checksum   <= checksum + wr_ent[7:0];
                    if (wr_end > hw) hw <= wr_end;
                end
                if (drop) load_err <= 1'b1;
                if ((state_next == ST_DONE) && (state != ST_DONE)) begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                end
            end

            if ((state == ST_DRAIN) && (state_next == ST_PAD)) pad_addr <= hw;
            else if (pad_wr)                                   pad_addr <= pad_addr + (ADDR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_mp1000_cart_loader.sv
// Randomized bench for mp1000_cart_loader against a queue-based model of the
// expected RAM write sequence and load status.
module tb_mp1000_cart_loader;

    localparam int ROM = 4096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        ram_ready;
    logic        ram_we;
    logic [11:0] ram_ad;
    logic [7:0]  ram_d;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [12:0] byte_count;
    logic [7:0]  checksum;

    always #5 clk = ~clk;

    mp1000_cart_loader dut (
        .clk_sys        (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ram_ready      (ram_ready),
        .ram_we         (ram_we),
        .ram_ad         (ram_ad),
        .ram_d          (ram_d),
        .cpu_hold       (cpu_hold),
        .load_done      (load_done),
        .load_err       (load_err),
        .byte_count     (byte_count),
        .checksum       (checksum)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          ready_mode = 0;
    logic [19:0] cap_q[$];
    logic [19:0] exp_q[$];
    int          m_cnt, m_hw;
    logic [7:0]  m_sum;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (ram_we) cap_q.push_back({ram_ad, ram_d});

    initial begin
        ram_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ram_ready = 1'b1;
                1:       ram_ready = 1'b0;
                default: ram_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic start_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick;
        exp_q.delete();
        cap_q.delete();
        m_cnt = 0;
        m_hw  = 0;
        m_sum = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d, input bit obey, input bit will_drop);
        int guard = 0;
        while (obey && ioctl_wait && guard < 2000) begin
            tick;
            guard++;
        end
        if (guard >= 2000) chk("wait_bound", 32'(ioctl_wait), 32'd0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick;
        ioctl_wr   = 1'b0;
        if (int'(a) < ROM && !will_drop) begin
            exp_q.push_back({a[11:0], d});
            m_cnt++;
            m_sum = m_sum + d;
            if (int'(a) + 1 > m_hw) m_hw = int'(a) + 1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic verify_log;
        int n_pad = ROM - m_hw;
        int bad_s = 0;
        int bad_p = 0;
        logic [11:0] pa;
        chk("log_len", 32'(cap_q.size()), 32'(exp_q.size() + n_pad));
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) bad_s++;
        for (int j = 0; j < n_pad; j++) begin
            int k = exp_q.size() + j;
            pa = 12'(m_hw + j);
            if (k >= cap_q.size() || cap_q[k] !== {pa, 8'hFF}) bad_p++;
        end
        chk("log_stream", 32'(bad_s), 32'd0);
        chk("log_pad", 32'(bad_p), 32'd0);
    endtask

    task automatic end_load;
        int guard = 0;
        ioctl_download = 1'b0;
        while (!load_done && guard < 20000) begin
            tick;
            guard++;
        end
        chk("load_done", 32'(load_done), 32'd1);
        repeat (3) tick;
        chk("load_done_hold", 32'(load_done), 32'd1);
        chk("cpu_hold_rel", 32'(cpu_hold), 32'd0);
        chk("byte_count", 32'(byte_count), 32'((m_cnt > ROM) ? ROM : m_cnt));
        chk("checksum", 32'(checksum), 32'(m_sum));
        chk("load_err", 32'(load_err), 32'(m_err));
        verify_log();
    endtask

    initial begin
        logic [12:0] bc_prev;
        int          guard;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        ready_mode     = 0;
        repeat (3) tick;
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_cnt", 32'(byte_count), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick;

        // Sequential 16-byte image with RAM always ready.
        start_load(8'h01);
        chk("cpu_hold_on", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send(25'(i), 8'(i), 1'b1, 1'b0);
            if (i == 0) chk("lat1_we", 32'(ram_we), 32'd1);
            if (i == 5) chk("lat1_ad", 32'({ram_ad, ram_d}), 32'({12'd5, 8'd5}));
        end
        end_load();
        chk("t1_sum", 32'(checksum), 32'h78);
        chk("t1_cnt", 32'(byte_count), 32'd16);

        // Backpressure with RAM stalled, then released under random grants.
        ready_mode = 1;
        repeat (2) tick;
        start_load(8'h01);
        for (int i = 0; i < 3; i++) begin
            send(25'(i), 8'($urandom), 1'b1, 1'b0);
            if (i == 1) chk("wait_lo_2", 32'(ioctl_wait), 32'd0);
        end
        chk("wait_hi_3", 32'(ioctl_wait), 32'd1);
        chk("no_we_rdy0", 32'(cap_q.size()), 32'd0);
        ready_mode = 2;
        for (int i = 3; i < 8; i++) send(25'(i), 8'($urandom), 1'b1, 1'b0);
        end_load();

        // Out-of-range strobe in the middle of a load.
        ready_mode = 0;
        start_load(8'h01);
        for (int i = 0; i < 4; i++) send(25'(i), 8'($urandom), 1'b1, 1'b0);
        send(25'h1000, 8'hA5, 1'b1, 1'b0);
        chk("oob_no_we", 32'(ram_we), 32'd0);
        chk("oob_err", 32'(load_err), 32'd1);
        for (int i = 4; i < 6; i++) send(25'(i), 8'($urandom), 1'b1, 1'b0);
        end_load();

        // Overflow: HPS ignores wait while RAM is stalled; fifth byte is lost.
        ready_mode = 1;
        repeat (2) tick;
        start_load(8'h01);
        for (int i = 0; i < 5; i++) send(25'(3000 + i), 8'($urandom), 1'b0, i == 4);
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_no_we", 32'(cap_q.size()), 32'd0);
        ready_mode = 0;
        end_load();

        // Foreign index is ignored.
        bc_prev        = byte_count;
        cap_q.delete();
        ioctl_index    = 8'h02;
        ioctl_download = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 25'(i);
            ioctl_dout = 8'($urandom);
            ioctl_wr   = 1'b1;
            tick;
            ioctl_wr   = 1'b0;
        end
        chk("idx2_hold", 32'(cpu_hold), 32'd0);
        chk("idx2_wait", 32'(ioctl_wait), 32'd0);
        chk("idx2_done", 32'(load_done), 32'd1);
        chk("idx2_cnt", 32'(byte_count), 32'(bc_prev));
        repeat (3) tick;
        chk("idx2_no_we", 32'(cap_q.size()), 32'd0);
        ioctl_download = 1'b0;
        repeat (2) tick;

        // New download arriving during pad aborts the pad.
        start_load(8'h01);
        for (int i = 0; i < 4; i++) send(25'(i), 8'($urandom), 1'b1, 1'b0);
        ioctl_download = 1'b0;
        guard = 0;
        while (cap_q.size() < 24 && guard < 5000) begin
            tick;
            guard++;
        end
        chk("t5_pad_start", 32'(cap_q.size() > 4 ? cap_q[4] : 20'h0), 32'({12'd4, 8'hFF}));
        start_load(8'h01);
        chk("t5_cnt_clr", 32'(byte_count), 32'd0);
        chk("t5_sum_clr", 32'(checksum), 32'd0);
        chk("t5_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 8; i++) send(25'(100 + i), 8'($urandom), 1'b1, 1'b0);
        end_load();

        // Randomized loads in the upper half with random grants and gaps.
        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(6, 30);
            ready_mode = 2;
            start_load(8'h01);
            for (int i = 0; i < n; i++) begin
                logic [24:0] a;
                if ($urandom_range(0, 15) == 0) a = 25'h1000 + 25'($urandom_range(0, 255));
                else                            a = 25'($urandom_range(2048, 4095));
                repeat ($urandom_range(0, 2)) tick;
                send(a, 8'($urandom), 1'b1, 1'b0);
            end
            if (r == 2) send(25'd4095, 8'($urandom), 1'b1, 1'b0);
            end_load();
        end

        // Reset in the middle of a load with two buffered bytes.
        ready_mode = 1;
        repeat (2) tick;
        start_load(8'h01);
        send(25'd10, 8'h11, 1'b1, 1'b0);
        send(25'd11, 8'h22, 1'b1, 1'b0);
        chk("t6_buffered", 32'(cap_q.size()), 32'd0);
        cap_q.delete();
        reset_n = 1'b0;
        #1;
        chk("t6_we", 32'(ram_we), 32'd0);
        chk("t6_hold", 32'(cpu_hold), 32'd0);
        chk("t6_cnt", 32'(byte_count), 32'd0);
        chk("t6_sum", 32'(checksum), 32'd0);
        chk("t6_ad_d", 32'({ram_ad, ram_d}), 32'd0);
        chk("t6_wait", 32'(ioctl_wait), 32'd0);
        ioctl_download = 1'b0;
        ready_mode     = 0;
        repeat (3) tick;
        reset_n = 1'b1;
        repeat (20) tick;
        chk("t6_no_we", 32'(cap_q.size()), 32'd0);
        chk("t6_done", 32'(load_done), 32'd0);

        start_load(8'h01);
        for (int i = 0; i < 3; i++) send(25'(4000 + i), 8'($urandom), 1'b1, 1'b0);
        end_load();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
